// File: rtl/ex_exec_pkg.sv
// rtl/ex_exec_pkg.sv - EX-stage ALU/quick-compare encodings, FSM states and shift kinds
package ex_exec_pkg;

    localparam logic [7:0] SELECT_ALU_DC8  = 8'h00;
    localparam logic [7:0] SELECT_ALU_ADD  = 8'h01;
    localparam logic [7:0] SELECT_ALU_SUB  = 8'h02;
    localparam logic [7:0] SELECT_ALU_SLT  = 8'h03;
    localparam logic [7:0] SELECT_ALU_SLTU = 8'h04;
    localparam logic [7:0] SELECT_ALU_AND  = 8'h05;
    localparam logic [7:0] SELECT_ALU_OR   = 8'h06;
    localparam logic [7:0] SELECT_ALU_XOR  = 8'h07;
    localparam logic [7:0] SELECT_ALU_NOR  = 8'h08;
    localparam logic [7:0] SELECT_ALU_SLL  = 8'h09;
    localparam logic [7:0] SELECT_ALU_SRL  = 8'h0A;
    localparam logic [7:0] SELECT_ALU_SRA  = 8'h0B;

    localparam logic [5:0] SELECT_QC_DC6 = 6'h00;
    localparam logic [5:0] SELECT_QC_EQ  = 6'h01;
    localparam logic [5:0] SELECT_QC_NE  = 6'h02;
    localparam logic [5:0] SELECT_QC_LEZ = 6'h03;
    localparam logic [5:0] SELECT_QC_GTZ = 6'h04;
    localparam logic [5:0] SELECT_QC_LTZ = 6'h05;
    localparam logic [5:0] SELECT_QC_GEZ = 6'h06;

    typedef enum logic {
        EX_IDLE,
        EX_SHIFT
    } ex_state_e;

    typedef enum logic [1:0] {
        SHK_SLL = 2'd0,
        SHK_SRL = 2'd1,
        SHK_SRA = 2'd2
    } shift_kind_e;

    function automatic logic is_shift_op(input logic [7:0] alusel);
        return (alusel == SELECT_ALU_SLL) || (alusel == SELECT_ALU_SRL) ||
               (alusel == SELECT_ALU_SRA);
    endfunction

endpackage

// File: rtl/ex_exec_qcmp.sv
// rtl/ex_exec_qcmp.sv - combinational quick comparator, shared with the ID-stage branch logic
module ex_qcmp
    import ex_exec_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [5:0]  qcsel_i,
    output logic        taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (qcsel_i)
            SELECT_QC_EQ:  taken_o = (a_i == b_i);
            SELECT_QC_NE:  taken_o = (a_i != b_i);
            SELECT_QC_LEZ: taken_o = a_i[31] || (a_i == 32'd0);
            SELECT_QC_GTZ: taken_o = !a_i[31] && (a_i != 32'd0);
            SELECT_QC_LTZ: taken_o = a_i[31];
            SELECT_QC_GEZ: taken_o = !a_i[31];
            SELECT_QC_DC6: taken_o = 1'b0;
            default:       taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_exec.sv
// rtl/ex_exec.sv - EX-stage execution unit: single-cycle ALU and quick compare, iterative shifter
module ex_exec
    import ex_exec_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        InValid,
    input  logic        Flush,
    input  logic [7:0]  ALUsel,
    input  logic [5:0]  QCsel,
    input  logic        UseImm,
    input  logic [31:0] RegA,
    input  logic [31:0] RegB,
    input  logic [31:0] Imm,
    input  logic [4:0]  Shamt,
    output logic        Busy,
    output logic        ResultValid,
    output logic [31:0] Result,
    output logic        Taken
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    ex_state_e   state_q, state_d;
    shift_kind_e sh_kind_q, sh_kind_d, kind_in;
    logic [31:0] sh_val_q, sh_val_d;
    logic [4:0]  sh_rem_q, sh_rem_d;
    logic [31:0] result_q, result_d;
    logic        taken_q, taken_d;
    logic        valid_q, valid_d;

    logic [31:0] op_b, alu_res, shifted;
    logic [4:0]  sh_amt, step_n;
    logic        qc_taken;

    ex_qcmp u_qcmp (
        .a_i     (RegA),
        .b_i     (op_b),
        .qcsel_i (QCsel),
        .taken_o (qc_taken)
    );

    always_comb begin
        op_b   = UseImm ? Imm : RegB;
        sh_amt = UseImm ? Shamt : RegA[4:0];
    end

    always_comb begin
        alu_res = 32'd0;
        case (ALUsel)
            SELECT_ALU_ADD:  alu_res = RegA + op_b;
            SELECT_ALU_SUB:  alu_res = RegA - op_b;
            SELECT_ALU_SLT:  alu_res = {31'd0, $signed(RegA) < $signed(op_b)};
            SELECT_ALU_SLTU: alu_res = {31'd0, RegA < op_b};
            SELECT_ALU_AND:  alu_res = RegA & op_b;
            SELECT_ALU_OR:   alu_res = RegA | op_b;
            SELECT_ALU_XOR:  alu_res = RegA ^ op_b;
            SELECT_ALU_NOR:  alu_res = ~(RegA | op_b);
            SELECT_ALU_DC8:  alu_res = 32'd0;
            default:         alu_res = 32'd0;
        endcase
    end

    always_comb begin
        kind_in = SHK_SLL;
        if (ALUsel == SELECT_ALU_SRL) begin
            kind_in = SHK_SRL;
        end else if (ALUsel == SELECT_ALU_SRA) begin
            kind_in = SHK_SRA;
        end
    end

    // The sign bit never changes during sra, so shifting the partial value keeps the original B[31] fill.
    always_comb begin
        step_n = (sh_rem_q < STEP) ? sh_rem_q : STEP;
        case (sh_kind_q)
            SHK_SRL: shifted = sh_val_q >> step_n;
            SHK_SRA: shifted = $signed(sh_val_q) >>> step_n;
            default: shifted = sh_val_q << step_n;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sh_kind_d = sh_kind_q;
        sh_val_d  = sh_val_q;
        sh_rem_d  = sh_rem_q;
        result_d  = result_q;
        taken_d   = taken_q;
        valid_d   = 1'b0;
        if (Flush) begin
            state_d = EX_IDLE;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (InValid) begin
                        if (is_shift_op(ALUsel) && (sh_amt != 5'd0)) begin
                            state_d   = EX_SHIFT;
                            sh_kind_d = kind_in;
                            sh_val_d  = op_b;
                            sh_rem_d  = sh_amt;
                        end else if (is_shift_op(ALUsel)) begin
                            result_d = op_b;
                            taken_d  = 1'b0;
                            valid_d  = 1'b1;
                        end else begin
                            result_d = alu_res;
                            taken_d  = qc_taken;
                            valid_d  = 1'b1;
                        end
                    end
                end
                EX_SHIFT: begin
                    sh_val_d = shifted;
                    sh_rem_d = sh_rem_q - step_n;
                    if (sh_rem_q == step_n) begin
                        state_d  = EX_IDLE;
                        result_d = shifted;
                        taken_d  = 1'b0;
                        valid_d  = 1'b1;
                    end
                end
                default: state_d = EX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= EX_IDLE;
            sh_kind_q <= SHK_SLL;
            sh_val_q  <= 32'd0;
            sh_rem_q  <= 5'd0;
            result_q  <= 32'd0;
            taken_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_kind_q <= sh_kind_d;
            sh_val_q  <= sh_val_d;
            sh_rem_q  <= sh_rem_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
            valid_q   <= valid_d;
        end
    end

    assign Busy        = (state_q == EX_SHIFT);
    assign ResultValid = valid_q;
    assign Result      = result_q;
    assign Taken       = taken_q;

endmodule

// File: tb/tb_ex_exec.sv
// tb/tb_ex_exec.sv - directed bench for ex_exec with SHIFT_STEP 1 and 4 against a transaction model
module tb_ex_exec;
    import ex_exec_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        InValid, Flush, UseImm;
    logic [7:0]  ALUsel;
    logic [5:0]  QCsel;
    logic [31:0] RegA, RegB, Imm;
    logic [4:0]  Shamt;

    logic [1:0]  busy, rv, tk;
    logic [31:0] res [2];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int          pend [2]     = '{0, 0};
    logic [31:0] pend_res [2] = '{0, 0};
    logic [31:0] exp_res [2]  = '{0, 0};
    logic        exp_rv [2]   = '{0, 0};
    logic        exp_tk [2]   = '{0, 0};
    logic        exp_busy [2] = '{0, 0};
    logic [31:0] m_r;
    logic        m_t;
    int          m_lat;

    always #5 CLK = ~CLK;

    ex_exec #(.SHIFT_STEP(1)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .InValid(InValid), .Flush(Flush), .ALUsel(ALUsel),
        .QCsel(QCsel), .UseImm(UseImm), .RegA(RegA), .RegB(RegB), .Imm(Imm), .Shamt(Shamt),
        .Busy(busy[0]), .ResultValid(rv[0]), .Result(res[0]), .Taken(tk[0])
    );

    ex_exec #(.SHIFT_STEP(4)) u_dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .InValid(InValid), .Flush(Flush), .ALUsel(ALUsel),
        .QCsel(QCsel), .UseImm(UseImm), .RegA(RegA), .RegB(RegB), .Imm(Imm), .Shamt(Shamt),
        .Busy(busy[1]), .ResultValid(rv[1]), .Result(res[1]), .Taken(tk[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Whole-op model: final value and edge count from accept to pulse.
    task automatic model_op(input logic [7:0] al, input logic [5:0] qc, input logic ui,
                            input logic [31:0] a, input logic [31:0] rb, input logic [31:0] imm,
                            input logic [4:0] sa, input int step,
                            output logic [31:0] r, output logic t, output int lat);
        logic [31:0] b;
        int amt;
        b   = ui ? imm : rb;
        amt = ui ? int'(sa) : int'(a[4:0]);
        r = 32'd0; t = 1'b0; lat = 1;
        case (al)
            SELECT_ALU_ADD:  r = a + b;
            SELECT_ALU_SUB:  r = a - b;
            SELECT_ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SELECT_ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            SELECT_ALU_AND:  r = a & b;
            SELECT_ALU_OR:   r = a | b;
            SELECT_ALU_XOR:  r = a ^ b;
            SELECT_ALU_NOR:  r = ~(a | b);
            SELECT_ALU_SLL:  r = b << amt;
            SELECT_ALU_SRL:  r = b >> amt;
            SELECT_ALU_SRA:  r = 32'($signed(b) >>> amt);
            default:         r = 32'd0;
        endcase
        if (al == SELECT_ALU_SLL || al == SELECT_ALU_SRL || al == SELECT_ALU_SRA) begin
            lat = (amt == 0) ? 1 : (amt + step - 1) / step + 1;
        end else begin
            case (qc)
                SELECT_QC_EQ:  t = (a == b);
                SELECT_QC_NE:  t = (a != b);
                SELECT_QC_LEZ: t = ($signed(a) <= 0);
                SELECT_QC_GTZ: t = ($signed(a) > 0);
                SELECT_QC_LTZ: t = ($signed(a) < 0);
                SELECT_QC_GEZ: t = ($signed(a) >= 0);
                default:       t = 1'b0;
            endcase
        end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        for (int k = 0; k < 2; k++) begin
            if (!RESET_N) begin
                pend[k] = 0; exp_res[k] = 32'd0; exp_tk[k] = 1'b0; exp_rv[k] = 1'b0;
            end else begin
                exp_rv[k] = 1'b0;
                if (Flush) begin
                    pend[k] = 0;
                end else if (pend[k] > 0) begin
                    pend[k]--;
                    if (pend[k] == 0) begin
                        exp_res[k] = pend_res[k]; exp_tk[k] = 1'b0; exp_rv[k] = 1'b1;
                    end
                end else if (InValid) begin
                    model_op(ALUsel, QCsel, UseImm, RegA, RegB, Imm, Shamt, step_of(k), m_r, m_t, m_lat);
                    if (m_lat == 1) begin
                        exp_res[k] = m_r; exp_tk[k] = m_t; exp_rv[k] = 1'b1;
                    end else begin
                        pend[k] = m_lat - 1; pend_res[k] = m_r;
                    end
                end
            end
            exp_busy[k] = (pend[k] > 0);
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(exp_busy[k]));
                chk($sformatf("valid%0d", k), 32'(rv[k]), 32'(exp_rv[k]));
                chk($sformatf("result%0d", k), res[k], exp_res[k]);
                chk($sformatf("taken%0d", k), 32'(tk[k]), 32'(exp_tk[k]));
            end
        end
    end

    task automatic drive(input logic [7:0] al, input logic [5:0] qc, input logic ui,
                         input logic [31:0] a, input logic [31:0] rb, input logic [31:0] imm,
                         input logic [4:0] sa);
        ALUsel = al; QCsel = qc; UseImm = ui; RegA = a; RegB = rb; Imm = imm; Shamt = sa;
        InValid = 1'b1;
    endtask

    task automatic single(input string nm, input logic [7:0] al, input logic [5:0] qc,
                          input logic ui, input logic [31:0] a, input logic [31:0] rb,
                          input logic [31:0] imm, input logic [4:0] sa,
                          input logic [31:0] er, input logic et);
        @(negedge CLK);
        drive(al, qc, ui, a, rb, imm, sa);
        @(negedge CLK);
        InValid = 1'b0;
        chk({nm, "_valid"}, 32'(rv[0]), 32'd1);
        chk({nm, "_result"}, res[0], er);
        chk({nm, "_taken"}, 32'(tk[0]), 32'(et));
    endtask

    task automatic wait_rv(input int k, input int maxe, output int edges);
        bit got;
        got = 1'b0;
        edges = 0;
        for (int i = 0; i < maxe && !got; i++) begin
            @(negedge CLK);
            InValid = 1'b0;
            edges++;
            if (rv[k]) got = 1'b1;
        end
        chk($sformatf("wait_valid%0d_timeout", k), 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 64 && !idle; i++) begin
            @(negedge CLK);
            InValid = 1'b0;
            if (busy == 2'b00) idle = 1'b1;
        end
        chk("wait_idle_timeout", 32'(idle), 32'd1);
    endtask

    initial begin
        int edges, nbusy;
        bit got;
        RESET_N = 1'b0; InValid = 1'b0; Flush = 1'b0; UseImm = 1'b0;
        ALUsel = SELECT_ALU_DC8; QCsel = SELECT_QC_DC6;
        RegA = 32'd0; RegB = 32'd0; Imm = 32'd0; Shamt = 5'd0;
        repeat (3) @(negedge CLK);
        cmp_en = 1'b1;
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_valid", 32'(rv[0]), 32'd0);
        chk("reset_result", res[0], 32'd0);
        chk("reset_taken", 32'(tk[0]), 32'd0);
        RESET_N = 1'b1;

        single("add_wrap", SELECT_ALU_ADD, SELECT_QC_DC6, 1'b1, 32'h7FFF_FFFF, 32'd0, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
        @(negedge CLK);
        chk("add_pulse_once", 32'(rv[0]), 32'd0);
        single("slt", SELECT_ALU_SLT, SELECT_QC_DC6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd1, 1'b0);
        single("sltu", SELECT_ALU_SLTU, SELECT_QC_DC6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0, 1'b0);
        single("nor", SELECT_ALU_NOR, SELECT_QC_DC6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        single("sub_ltz", SELECT_ALU_SUB, SELECT_QC_LTZ, 1'b0, 32'hFFFF_FFFD, 32'd1, 32'd0, 5'd0, 32'hFFFF_FFFC, 1'b1);
        single("bad_alu", 8'hEE, SELECT_QC_DC6, 1'b0, 32'd9, 32'd9, 32'd0, 5'd0, 32'd0, 1'b0);

        // back-to-back single-cycle ops pulse on consecutive cycles
        @(negedge CLK);
        drive(SELECT_ALU_AND, SELECT_QC_DC6, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 5'd0);
        @(negedge CLK);
        drive(SELECT_ALU_XOR, SELECT_QC_DC6, 1'b0, 32'hAAAA_0000, 32'h5555_FFFF, 32'd0, 5'd0);
        chk("b2b_and", res[0], 32'h00F0_1234);
        @(negedge CLK);
        InValid = 1'b0;
        chk("b2b_valid2", 32'(rv[0]), 32'd1);
        chk("b2b_xor", res[0], 32'hFFFF_FFFF);

        // sra by 31 on the 1-bit shifter, with ops offered while busy
        @(negedge CLK);
        drive(SELECT_ALU_SRA, SELECT_QC_DC6, 1'b1, 32'd0, 32'd0, 32'h8000_0000, 5'd31);
        edges = 0; nbusy = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            edges++;
            if (busy[0]) nbusy++;
            if (rv[0]) got = 1'b1;
            else drive(SELECT_ALU_ADD, SELECT_QC_EQ, 1'b0, 32'(i), 32'd7, 32'd0, 5'd0);
        end
        InValid = 1'b0;
        chk("sra_timeout", 32'(got), 32'd1);
        chk("sra_edges", 32'(edges), 32'd32);
        chk("sra_busy_cycles", 32'(nbusy), 32'd31);
        chk("sra_result", res[0], 32'hFFFF_FFFF);
        wait_idle();

        single("srlv_zero", SELECT_ALU_SRL, SELECT_QC_DC6, 1'b0, 32'd0, 32'h1234_5678, 32'd0, 5'd5, 32'h1234_5678, 1'b0);
        chk("srlv_zero_busy", 32'(busy), 32'd0);
        single("sll_zero", SELECT_ALU_SLL, SELECT_QC_DC6, 1'b1, 32'd0, 32'd0, 32'h0000_ABCD, 5'd0, 32'h0000_ABCD, 1'b0);

        @(negedge CLK);
        drive(SELECT_ALU_SLL, SELECT_QC_DC6, 1'b1, 32'd0, 32'd0, 32'h0000_00F1, 5'd9);
        wait_rv(1, 40, edges);
        chk("sll4_edges", 32'(edges), 32'd4);
        chk("sll4_result", res[1], 32'h0001_E200);
        wait_idle();
        chk("sll1_result", res[0], 32'h0001_E200);

        // flush three cycles into a 20-bit shift
        single("pre_flush", SELECT_ALU_ADD, SELECT_QC_DC6, 1'b1, 32'd5, 32'd0, 32'd6, 5'd0, 32'd11, 1'b0);
        @(negedge CLK);
        drive(SELECT_ALU_SRL, SELECT_QC_DC6, 1'b1, 32'd0, 32'd0, 32'hFFFF_0000, 5'd20);
        @(negedge CLK);
        InValid = 1'b0;
        repeat (2) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(rv), 32'd0);
        chk("flush_result1", res[0], 32'd11);
        chk("flush_result4", res[1], 32'd11);
        repeat (3) @(negedge CLK);

        // reset asserted mid-shift
        @(negedge CLK);
        drive(SELECT_ALU_SRL, SELECT_QC_DC6, 1'b1, 32'd0, 32'd0, 32'hFFFF_0000, 5'd20);
        @(negedge CLK);
        InValid = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(rv), 32'd0);
        chk("rst_mid_result", res[0], 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        single("bgez_zero", SELECT_ALU_DC8, SELECT_QC_GEZ, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        single("bgtz_zero", SELECT_ALU_DC8, SELECT_QC_GTZ, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        single("bne_equal", SELECT_ALU_XOR, SELECT_QC_NE, 1'b0, 32'd5, 32'd5, 32'd0, 5'd0, 32'd0, 1'b0);
        single("beq_equal", SELECT_ALU_OR, SELECT_QC_EQ, 1'b0, 32'd5, 32'd5, 32'd0, 5'd0, 32'd5, 1'b1);
        single("qc_dc6", SELECT_ALU_OR, SELECT_QC_DC6, 1'b0, 32'd5, 32'd5, 32'd0, 5'd0, 32'd5, 1'b0);
        single("blez_neg", SELECT_ALU_DC8, SELECT_QC_LEZ, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
